// File: rtl/llsc_issue_queue_pkg.sv
// Shared LL/SC types: memory-op encoding, reservation tracker size and the
// issue-queue entry state.
package llsc_issue_queue_pkg;

  localparam int LLSC_SIZE = 8;

  typedef enum logic [2:0] {
    IS_NO_MEM_INST = 3'd0,
    IS_LD          = 3'd1,
    IS_ST          = 3'd2,
    IS_LDL         = 3'd3,
    IS_STQ         = 3'd4,
    IS_STQ_C       = 3'd5
  } MEM_INST_TYPE;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_PEND  = 2'd1,
    Q_WB    = 2'd2,
    Q_DONE  = 2'd3
  } LLSC_Q_STATE;

  function automatic logic is_llsc_op(input MEM_INST_TYPE t);
    return (t == IS_LDL) || (t == IS_STQ) || (t == IS_STQ_C);
  endfunction

endpackage

// File: rtl/llsc_issue_queue_if.sv
// Enqueue, tracker-query and CDB signals of the LL/SC issue queue.
// master = dispatch/tracker/CDB side, slave = the queue itself.
interface llsc_issue_queue_if import llsc_issue_queue_pkg::*; #(
  parameter int DEPTH = LLSC_SIZE,
  parameter int PRF_W = 6,
  parameter int ROB_W = 5
) ();
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [1:0]       in_valid;
  MEM_INST_TYPE     in_type     [2];
  logic [63:0]      in_addr     [2];
  logic [PRF_W-1:0] in_dest_prf [2];
  logic [ROB_W-1:0] in_rob_idx  [2];
  logic             in_ready;

  MEM_INST_TYPE     inst1_mem_inst_type;
  MEM_INST_TYPE     inst2_mem_inst_type;
  logic [63:0]      inst1_mem_addr;
  logic [63:0]      inst2_mem_addr;
  logic             inst1_store_success;
  logic             inst2_store_success;

  logic             cdb_valid;
  logic [PRF_W-1:0] cdb_dest_prf;
  logic [ROB_W-1:0] cdb_rob_idx;
  logic [63:0]      cdb_value;
  logic             cdb_ready;

  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, in_type, in_addr, in_dest_prf, in_rob_idx,
    output inst1_store_success, inst2_store_success, cdb_ready,
    input  in_ready, inst1_mem_inst_type, inst2_mem_inst_type,
    input  inst1_mem_addr, inst2_mem_addr,
    input  cdb_valid, cdb_dest_prf, cdb_rob_idx, cdb_value, count
  );

  modport slave (
    input  in_valid, in_type, in_addr, in_dest_prf, in_rob_idx,
    input  inst1_store_success, inst2_store_success, cdb_ready,
    output in_ready, inst1_mem_inst_type, inst2_mem_inst_type,
    output inst1_mem_addr, inst2_mem_addr,
    output cdb_valid, cdb_dest_prf, cdb_rob_idx, cdb_value, count
  );

endinterface

// File: rtl/llsc_issue_queue.sv
// In-order LL/SC issue buffer: two-wide enqueue, two tracker query slots,
// in-order retire with STQ_C results written back over one CDB port.
//   state   | meaning
//   Q_EMPTY | slot free
//   Q_PEND  | enqueued, waiting for a tracker query slot
//   Q_WB    | STQ_C queried, success bit latched, waiting for CDB grant
//   Q_DONE  | LDL/STQ queried, retires without writeback
module llsc_issue_queue import llsc_issue_queue_pkg::*; #(
  parameter int DEPTH = LLSC_SIZE,
  parameter int PRF_W = 6,
  parameter int ROB_W = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  llsc_issue_queue_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [IW-1:0] idx_t;

  LLSC_Q_STATE      st_q   [DEPTH];
  LLSC_Q_STATE      st_d   [DEPTH];
  MEM_INST_TYPE     ty_q   [DEPTH];
  MEM_INST_TYPE     ty_d   [DEPTH];
  logic [63:0]      addr_q [DEPTH];
  logic [63:0]      addr_d [DEPTH];
  logic [PRF_W-1:0] dest_q [DEPTH];
  logic [PRF_W-1:0] dest_d [DEPTH];
  logic [ROB_W-1:0] rob_q  [DEPTH];
  logic [ROB_W-1:0] rob_d  [DEPTH];
  logic             succ_q [DEPTH];
  logic             succ_d [DEPTH];

  ptr_t head_q, head_d, iss_q, iss_d, tail_q, tail_d;
  ptr_t occ;
  idx_t h0_i, h1_i, s0_i, s1_i, t0_i, t1_i, cdb_i;
  logic in_rdy, en_ok, e0, e1;
  logic q1_v, q2_v;
  logic cdb_on_h1, cdb_v, fire, pop0, pop1;
  LLSC_Q_STATE h0_st, h1_st;

  assign occ    = tail_q - head_q;
  assign in_rdy = (occ <= ptr_t'(DEPTH - 2));

  assign h0_i = head_q[IW-1:0];
  assign h1_i = h0_i + idx_t'(1);
  assign s0_i = iss_q[IW-1:0];
  assign s1_i = s0_i + idx_t'(1);
  assign t0_i = tail_q[IW-1:0];
  assign t1_i = t0_i + idx_t'(e0);

  // Slot 2 is checked by the tracker against pre-update state, so a same-address
  // pair would see a stale reservation; it waits one cycle instead.
  assign q1_v = !flush && (st_q[s0_i] == Q_PEND);
  assign q2_v = q1_v && (st_q[s1_i] == Q_PEND) && (addr_q[s1_i] != addr_q[s0_i]);

  assign h0_st     = st_q[h0_i];
  assign h1_st     = st_q[h1_i];
  assign cdb_on_h1 = (h0_st == Q_DONE) && (h1_st == Q_WB);
  assign cdb_v     = !flush && ((h0_st == Q_WB) || cdb_on_h1);
  assign cdb_i     = cdb_on_h1 ? h1_i : h0_i;
  assign fire      = cdb_v && bus.cdb_ready;
  assign pop0      = (h0_st == Q_DONE) || ((h0_st == Q_WB) && fire);
  assign pop1      = pop0 && ((h1_st == Q_DONE) || (cdb_on_h1 && fire));

  assign en_ok = in_rdy && !flush;
  assign e0    = en_ok && bus.in_valid[0] && is_llsc_op(bus.in_type[0]);
  assign e1    = en_ok && bus.in_valid[1] && is_llsc_op(bus.in_type[1]);

  assign bus.in_ready            = in_rdy;
  assign bus.count               = occ;
  assign bus.inst1_mem_inst_type = q1_v ? ty_q[s0_i] : IS_NO_MEM_INST;
  assign bus.inst2_mem_inst_type = q2_v ? ty_q[s1_i] : IS_NO_MEM_INST;
  assign bus.inst1_mem_addr      = q1_v ? addr_q[s0_i] : 64'd0;
  assign bus.inst2_mem_addr      = q2_v ? addr_q[s1_i] : 64'd0;
  assign bus.cdb_valid           = cdb_v;
  assign bus.cdb_dest_prf        = cdb_v ? dest_q[cdb_i] : '0;
  assign bus.cdb_rob_idx         = cdb_v ? rob_q[cdb_i] : '0;
  assign bus.cdb_value           = {63'd0, cdb_v && succ_q[cdb_i]};

  always_comb begin
    st_d   = st_q;
    ty_d   = ty_q;
    addr_d = addr_q;
    dest_d = dest_q;
    rob_d  = rob_q;
    succ_d = succ_q;

    if (q1_v) begin
      st_d[s0_i]   = (ty_q[s0_i] == IS_STQ_C) ? Q_WB : Q_DONE;
      succ_d[s0_i] = bus.inst1_store_success;
    end
    if (q2_v) begin
      st_d[s1_i]   = (ty_q[s1_i] == IS_STQ_C) ? Q_WB : Q_DONE;
      succ_d[s1_i] = bus.inst2_store_success;
    end

    if (pop0) st_d[h0_i] = Q_EMPTY;
    if (pop1) st_d[h1_i] = Q_EMPTY;

    if (e0) begin
      st_d[t0_i]   = Q_PEND;
      ty_d[t0_i]   = bus.in_type[0];
      addr_d[t0_i] = bus.in_addr[0];
      dest_d[t0_i] = bus.in_dest_prf[0];
      rob_d[t0_i]  = bus.in_rob_idx[0];
      succ_d[t0_i] = 1'b0;
    end
    if (e1) begin
      st_d[t1_i]   = Q_PEND;
      ty_d[t1_i]   = bus.in_type[1];
      addr_d[t1_i] = bus.in_addr[1];
      dest_d[t1_i] = bus.in_dest_prf[1];
      rob_d[t1_i]  = bus.in_rob_idx[1];
      succ_d[t1_i] = 1'b0;
    end

    head_d = head_q + ptr_t'(pop0) + ptr_t'(pop1);
    iss_d  = iss_q + ptr_t'(q1_v) + ptr_t'(q2_v);
    tail_d = tail_q + ptr_t'(e0) + ptr_t'(e1);

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) st_d[i] = Q_EMPTY;
      head_d = '0;
      iss_d  = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]   <= Q_EMPTY;
        ty_q[i]   <= IS_NO_MEM_INST;
        addr_q[i] <= '0;
        dest_q[i] <= '0;
        rob_q[i]  <= '0;
        succ_q[i] <= 1'b0;
      end
      head_q <= '0;
      iss_q  <= '0;
      tail_q <= '0;
    end else begin
      st_q   <= st_d;
      ty_q   <= ty_d;
      addr_q <= addr_d;
      dest_q <= dest_d;
      rob_q  <= rob_d;
      succ_q <= succ_d;
      head_q <= head_d;
      iss_q  <= iss_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: tb/tb_llsc_issue_queue.sv
// Directed bench for llsc_issue_queue: issue, pairing hazard, CDB back-pressure,
// full/wrap, flush and asynchronous reset.
module tb_llsc_issue_queue;
  import llsc_issue_queue_pkg::*;

  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic reset;
  logic flush;
  int   n_chk  = 0;
  int   n_pass = 0;

  llsc_issue_queue_if #(.DEPTH(DEPTH), .PRF_W(6), .ROB_W(5)) bus ();

  llsc_issue_queue #(.DEPTH(DEPTH), .PRF_W(6), .ROB_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_in();
    bus.in_valid = 2'b00;
    for (int l = 0; l < 2; l++) begin
      bus.in_type[l]     = IS_NO_MEM_INST;
      bus.in_addr[l]     = 64'd0;
      bus.in_dest_prf[l] = 6'd0;
      bus.in_rob_idx[l]  = 5'd0;
    end
  endtask

  task automatic put(input int lane, input MEM_INST_TYPE t, input logic [63:0] a,
                     input logic [5:0] d, input logic [4:0] r);
    bus.in_valid[lane]    = 1'b1;
    bus.in_type[lane]     = t;
    bus.in_addr[lane]     = a;
    bus.in_dest_prf[lane] = d;
    bus.in_rob_idx[lane]  = r;
  endtask

  logic [5:0] exp_q [$];
  int         op_i;
  int         n_wb;
  logic [5:0] exp_d;

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    clr_in();
    bus.cdb_ready           = 1'b1;
    bus.inst1_store_success = 1'b1;
    bus.inst2_store_success = 1'b1;
    #2;
    chk("rst_count", bus.count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_cdb_valid", bus.cdb_valid, 0);
    chk("rst_cdb_dest", bus.cdb_dest_prf, 0);
    chk("rst_q1_type", bus.inst1_mem_inst_type, IS_NO_MEM_INST);
    chk("rst_q2_type", bus.inst2_mem_inst_type, IS_NO_MEM_INST);
    chk("rst_q1_addr", bus.inst1_mem_addr, 0);
    #10 reset = 1'b1;
    step();

    // single STQ_C, success
    put(0, IS_STQ_C, 64'h100, 6'd7, 5'd3);
    step(); clr_in();
    chk("t1_count_n1", bus.count, 1);
    chk("t1_q1_type", bus.inst1_mem_inst_type, IS_STQ_C);
    chk("t1_q1_addr", bus.inst1_mem_addr, 64'h100);
    chk("t1_q2_type", bus.inst2_mem_inst_type, IS_NO_MEM_INST);
    chk("t1_cdb_n1", bus.cdb_valid, 0);
    step();
    chk("t1_cdb_valid", bus.cdb_valid, 1);
    chk("t1_cdb_dest", bus.cdb_dest_prf, 7);
    chk("t1_cdb_rob", bus.cdb_rob_idx, 3);
    chk("t1_cdb_value", bus.cdb_value, 1);
    chk("t1_q1_idle", bus.inst1_mem_inst_type, IS_NO_MEM_INST);
    step();
    chk("t1_count_n3", bus.count, 0);
    chk("t1_cdb_n3", bus.cdb_valid, 0);

    // same-address pair: STQ_C waits a cycle, tracker says fail
    bus.inst1_store_success = 1'b0;
    bus.inst2_store_success = 1'b0;
    put(0, IS_LDL, 64'h200, 6'd0, 5'd1);
    put(1, IS_STQ_C, 64'h200, 6'd9, 5'd2);
    step(); clr_in();
    chk("t2_count", bus.count, 2);
    chk("t2_q1_type", bus.inst1_mem_inst_type, IS_LDL);
    chk("t2_q1_addr", bus.inst1_mem_addr, 64'h200);
    chk("t2_q2_type", bus.inst2_mem_inst_type, IS_NO_MEM_INST);
    chk("t2_q2_addr", bus.inst2_mem_addr, 0);
    step();
    chk("t2_q1_stqc", bus.inst1_mem_inst_type, IS_STQ_C);
    chk("t2_q2_idle", bus.inst2_mem_inst_type, IS_NO_MEM_INST);
    chk("t2_cdb_n2", bus.cdb_valid, 0);
    chk("t2_count_n2", bus.count, 2);
    step();
    chk("t2_count_n3", bus.count, 1);
    chk("t2_cdb_valid", bus.cdb_valid, 1);
    chk("t2_cdb_dest", bus.cdb_dest_prf, 9);
    chk("t2_cdb_value", bus.cdb_value, 0);
    step();
    chk("t2_count_n4", bus.count, 0);
    bus.inst1_store_success = 1'b1;
    bus.inst2_store_success = 1'b1;

    // distinct-address pair issues together
    put(0, IS_LDL, 64'h300, 6'd0, 5'd4);
    put(1, IS_STQ, 64'h308, 6'd0, 5'd5);
    step(); clr_in();
    chk("t2b_q1_type", bus.inst1_mem_inst_type, IS_LDL);
    chk("t2b_q2_type", bus.inst2_mem_inst_type, IS_STQ);
    chk("t2b_q2_addr", bus.inst2_mem_addr, 64'h308);
    step();
    chk("t2b_count", bus.count, 2);
    step();
    chk("t2b_count_end", bus.count, 0);

    // non-LL/SC op on lane 0 dropped; lane 1 lands at tail
    put(0, IS_LD, 64'h800, 6'd0, 5'd6);
    put(1, IS_STQ, 64'h808, 6'd0, 5'd7);
    step(); clr_in();
    chk("drop_count", bus.count, 1);
    chk("drop_q1_type", bus.inst1_mem_inst_type, IS_STQ);
    chk("drop_q1_addr", bus.inst1_mem_addr, 64'h808);
    step(); step();
    chk("drop_count_end", bus.count, 0);

    // three STQ_Cs held by cdb_ready=0
    bus.cdb_ready           = 1'b0;
    bus.inst2_store_success = 1'b0;
    put(0, IS_STQ_C, 64'h400, 6'd10, 5'd4);
    put(1, IS_STQ_C, 64'h408, 6'd11, 5'd5);
    step(); clr_in();
    put(0, IS_STQ_C, 64'h410, 6'd12, 5'd6);
    chk("t3_q2_type", bus.inst2_mem_inst_type, IS_STQ_C);
    chk("t3_q2_addr", bus.inst2_mem_addr, 64'h408);
    step(); clr_in();
    chk("t3_q1_addr", bus.inst1_mem_addr, 64'h410);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", bus.cdb_valid, 1);
      chk("t3_hold_dest", bus.cdb_dest_prf, 10);
      chk("t3_hold_rob", bus.cdb_rob_idx, 4);
      step();
    end
    chk("t3_hold_count", bus.count, 3);
    bus.cdb_ready = 1'b1;
    chk("t3_pop0_dest", bus.cdb_dest_prf, 10);
    chk("t3_pop0_value", bus.cdb_value, 1);
    step();
    chk("t3_pop1_dest", bus.cdb_dest_prf, 11);
    chk("t3_pop1_value", bus.cdb_value, 0);
    chk("t3_pop1_count", bus.count, 2);
    step();
    chk("t3_pop2_dest", bus.cdb_dest_prf, 12);
    chk("t3_pop2_value", bus.cdb_value, 1);
    step();
    chk("t3_end_valid", bus.cdb_valid, 0);
    chk("t3_end_count", bus.count, 0);
    bus.inst2_store_success = 1'b1;

    // fill to DEPTH-1
    bus.cdb_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      put(0, IS_STQ_C, 64'h2000 + 64'(k * 16), 6'(40 + 2 * k), 5'(k));
      put(1, IS_STQ_C, 64'h2008 + 64'(k * 16), 6'(41 + 2 * k), 5'(k));
      step(); clr_in();
    end
    chk("fill_ready_6", bus.in_ready, 1);
    put(0, IS_STQ_C, 64'h2100, 6'd46, 5'd9);
    step(); clr_in();
    chk("fill_count", bus.count, DEPTH - 1);
    chk("fill_ready", bus.in_ready, 0);
    put(0, IS_STQ_C, 64'h2200, 6'd50, 5'd10);
    put(1, IS_STQ_C, 64'h2208, 6'd51, 5'd11);
    step(); clr_in();
    chk("full_drop_count", bus.count, DEPTH - 1);
    chk("full_cdb_dest", bus.cdb_dest_prf, 40);
    bus.cdb_ready = 1'b1;
    step();
    chk("rel1_count", bus.count, DEPTH - 2);
    chk("rel1_ready", bus.in_ready, 1);
    chk("rel1_dest", bus.cdb_dest_prf, 41);
    step();
    chk("rel2_count", bus.count, DEPTH - 3);
    for (int i = 0; i < 30 && bus.count != 0; i++) step();
    chk("drain_count", bus.count, 0);

    // 3*DEPTH ops streamed through, scoreboarded in program order
    op_i = 0;
    n_wb = 0;
    for (int cyc = 0; cyc < 200 && (op_i < 3 * DEPTH || bus.count != 0); cyc++) begin
      if (bus.cdb_valid) begin
        n_wb++;
        if (exp_q.size() == 0) chk("wrap_sb_empty", 1, 0);
        else begin
          exp_d = exp_q.pop_front();
          chk("wrap_dest", bus.cdb_dest_prf, exp_d);
          chk("wrap_value", bus.cdb_value, 1);
        end
      end
      clr_in();
      if (bus.in_ready && op_i < 3 * DEPTH) begin
        for (int l = 0; l < 2; l++) begin
          if (op_i < 3 * DEPTH) begin
            put(l, (op_i % 2 == 1) ? IS_STQ_C : IS_LDL, 64'h1000 + 64'(op_i * 8),
                6'(op_i), 5'(op_i));
            if (op_i % 2 == 1) exp_q.push_back(6'(op_i));
            op_i++;
          end
        end
      end
      step();
    end
    clr_in();
    chk("wrap_count", bus.count, 0);
    chk("wrap_n_wb", n_wb, 3 * DEPTH / 2);
    chk("wrap_sb_left", exp_q.size(), 0);

    // flush with a WB pending and an enqueue arriving
    bus.cdb_ready = 1'b0;
    put(0, IS_STQ_C, 64'h600, 6'd20, 5'd8);
    step(); clr_in();
    put(0, IS_LDL, 64'h608, 6'd0, 5'd9);
    step(); clr_in();
    chk("fl_pre_cdb", bus.cdb_valid, 1);
    chk("fl_pre_q1", bus.inst1_mem_inst_type, IS_LDL);
    flush = 1'b1;
    put(0, IS_LDL, 64'h700, 6'd0, 5'd10);
    #1;
    chk("fl_cyc_q1", bus.inst1_mem_inst_type, IS_NO_MEM_INST);
    chk("fl_cyc_q1_addr", bus.inst1_mem_addr, 0);
    chk("fl_cyc_q2", bus.inst2_mem_inst_type, IS_NO_MEM_INST);
    chk("fl_cyc_cdb", bus.cdb_valid, 0);
    step();
    flush = 1'b0;
    clr_in();
    chk("fl_count", bus.count, 0);
    chk("fl_cdb", bus.cdb_valid, 0);
    chk("fl_q1", bus.inst1_mem_inst_type, IS_NO_MEM_INST);
    chk("fl_ready", bus.in_ready, 1);
    step();
    chk("fl_count2", bus.count, 0);

    // async reset mid-cycle with 4 entries held
    put(0, IS_STQ_C, 64'h900, 6'd30, 5'd1);
    put(1, IS_STQ_C, 64'h908, 6'd31, 5'd2);
    step(); clr_in();
    put(0, IS_STQ_C, 64'h910, 6'd32, 5'd3);
    put(1, IS_STQ_C, 64'h918, 6'd33, 5'd4);
    step(); clr_in();
    step();
    chk("ar_pre_count", bus.count, 4);
    chk("ar_pre_cdb", bus.cdb_valid, 1);
    #3 reset = 1'b0;
    #1;
    chk("ar_count", bus.count, 0);
    chk("ar_ready", bus.in_ready, 1);
    chk("ar_cdb", bus.cdb_valid, 0);
    chk("ar_cdb_dest", bus.cdb_dest_prf, 0);
    chk("ar_cdb_value", bus.cdb_value, 0);
    chk("ar_q1", bus.inst1_mem_inst_type, IS_NO_MEM_INST);
    #2 reset = 1'b1;
    bus.cdb_ready = 1'b1;
    step();
    chk("ar_post_count", bus.count, 0);
    chk("ar_post_cdb", bus.cdb_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
